// File: rtl/bsg_manycore_drlp_bcast_barrier_if.sv
// Bus bundle for the DRLP broadcast/barrier engine.
// Job request, master beat stream, slave broadcast, slave ready/done, and
// completion report. The slave modport is the engine side; the master
// modport is the master tile / slave row environment side.
interface bsg_manycore_drlp_bcast_barrier_if #(
   parameter int num_slaves_p  = 15,
   parameter int data_width_p  = 32,
   parameter int beats_width_p = 9
);
   logic                     job_v_i;
   logic                     job_ready_o;
   logic [num_slaves_p-1:0]  job_mask_i;
   logic [beats_width_p-1:0] job_beats_i;
   logic                     data_v_i;
   logic [data_width_p-1:0]  data_i;
   logic                     data_yumi_o;
   logic                     bcast_v_o;
   logic [data_width_p-1:0]  bcast_data_o;
   logic                     bcast_last_o;
   logic [num_slaves_p-1:0]  bcast_mask_o;
   logic [num_slaves_p-1:0]  slave_ready_i;
   logic [num_slaves_p-1:0]  slave_done_i;
   logic                     busy_o;
   logic                     done_v_o;
   logic                     done_err_o;
   logic [num_slaves_p-1:0]  done_missing_o;

   modport slave (
      input  job_v_i, job_mask_i, job_beats_i,
      input  data_v_i, data_i,
      input  slave_ready_i, slave_done_i,
      output job_ready_o, data_yumi_o,
      output bcast_v_o, bcast_data_o, bcast_last_o, bcast_mask_o,
      output busy_o, done_v_o, done_err_o, done_missing_o
   );

   modport master (
      output job_v_i, job_mask_i, job_beats_i,
      output data_v_i, data_i,
      output slave_ready_i, slave_done_i,
      input  job_ready_o, data_yumi_o,
      input  bcast_v_o, bcast_data_o, bcast_last_o, bcast_mask_o,
      input  busy_o, done_v_o, done_err_o, done_missing_o
   );
endinterface

// File: rtl/bsg_manycore_drlp_bcast_barrier.sv
// Broadcast-and-barrier engine: streams a job's beats to a masked set of
// DRLP slaves, then waits for their sticky done flags or a timeout.
// Ports: clk_i, reset_n_i (async active-low), bus (engine-side modport).
module bsg_manycore_drlp_bcast_barrier #(
   parameter int num_slaves_p     = 15,
   parameter int data_width_p     = 32,
   parameter int max_beats_p      = 304,
   parameter int timeout_cycles_p = 4096
) (
   input logic clk_i,
   input logic reset_n_i,
   bsg_manycore_drlp_bcast_barrier_if.slave bus
);
   localparam int beats_width_lp =
      (max_beats_p + 1 > 1) ? $clog2(max_beats_p + 1) : 1;
   localparam int cnt_width_lp =
      (timeout_cycles_p + 1 > 1) ? $clog2(timeout_cycles_p + 1) : 1;
   localparam logic [cnt_width_lp-1:0] cnt_last_lp =
      cnt_width_lp'((timeout_cycles_p == 0) ? 0 : timeout_cycles_p - 1);
   localparam logic [beats_width_lp-1:0] max_beats_lp =
      beats_width_lp'(max_beats_p);

   typedef enum logic [1:0] {IDLE, BCAST, WAIT_DONE, REPORT} state_e;

   state_e state_r, state_n;

   logic [num_slaves_p-1:0]   mask_r;
   logic [num_slaves_p-1:0]   sticky_r;
   logic [beats_width_lp-1:0] beats_left_r;
   logic                      bv_r;
   logic                      last_r;
   logic [data_width_p-1:0]   data_r;
   logic [cnt_width_lp-1:0]   cnt_r;
   logic                      err_r;

   logic                      accept;
   logic                      fire;
   logic                      yumi;
   logic                      complete;
   logic                      expire;
   logic                      sticky_en;
   logic [num_slaves_p-1:0]   seen;

   assign accept    = (state_r == IDLE) & bus.job_v_i;
   // Unmasked slaves never hold a beat back.
   assign fire      = bv_r & (&(bus.slave_ready_i | ~mask_r));
   assign yumi      = (state_r == BCAST) & bus.data_v_i
                    & (beats_left_r != '0) & (~bv_r | fire);
   assign sticky_en = (state_r == BCAST) | (state_r == WAIT_DONE);
   // Same-cycle done counts toward completion.
   assign seen      = sticky_r | (bus.slave_done_i & mask_r);
   assign complete  = &(seen | ~mask_r);
   assign expire    = (timeout_cycles_p != 0) && (cnt_r == cnt_last_lp);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= IDLE;
      else            state_r <= state_n;
   end

   always_comb begin
      state_n             = state_r;
      bus.job_ready_o     = 1'b0;
      bus.busy_o          = 1'b1;
      bus.bcast_mask_o    = mask_r;
      bus.done_v_o        = 1'b0;
      bus.done_err_o      = 1'b0;
      bus.done_missing_o  = '0;
      unique case (state_r)
         IDLE: begin
            bus.job_ready_o  = 1'b1;
            bus.busy_o       = 1'b0;
            bus.bcast_mask_o = '0;
            if (accept)
               state_n = (bus.job_beats_i == '0) ? WAIT_DONE : BCAST;
         end
         BCAST: begin
            if (fire & last_r) state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (complete | expire) state_n = REPORT;
         end
         REPORT: begin
            bus.done_v_o       = 1'b1;
            bus.done_err_o     = err_r;
            bus.done_missing_o = mask_r & ~sticky_r;
            state_n            = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mask_r       <= '0;
         sticky_r     <= '0;
         beats_left_r <= '0;
         bv_r         <= 1'b0;
         last_r       <= 1'b0;
         data_r       <= '0;
         cnt_r        <= '0;
         err_r        <= 1'b0;
      end else begin
         if (accept) begin
            mask_r       <= bus.job_mask_i;
            beats_left_r <= bus.job_beats_i;
            sticky_r     <= '0;
         end else if (sticky_en) begin
            sticky_r <= seen;
         end
         if (yumi) begin
            data_r       <= bus.data_i;
            bv_r         <= 1'b1;
            last_r       <= (beats_left_r == beats_width_lp'(1));
            beats_left_r <= beats_left_r - beats_width_lp'(1);
         end else if (fire) begin
            bv_r   <= 1'b0;
            last_r <= 1'b0;
         end
         if (state_r == WAIT_DONE) cnt_r <= cnt_r + cnt_width_lp'(1);
         else                      cnt_r <= '0;
         // On the exit cycle this holds 1 only for a timeout exit.
         if (state_r == WAIT_DONE) err_r <= ~complete;
      end
   end

   assign bus.data_yumi_o  = yumi;
   assign bus.bcast_v_o    = bv_r;
   assign bus.bcast_data_o = data_r;
   assign bus.bcast_last_o = last_r;

   a_beats_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      accept |-> (bus.job_beats_i <= max_beats_lp));
endmodule

// File: tb/tb_bsg_manycore_drlp_bcast_barrier.sv
// Self-checking bench for the DRLP broadcast/barrier engine.
// Directed scenarios plus randomized jobs against a timing model.
module tb_bsg_manycore_drlp_bcast_barrier;
   localparam int NS = 4;
   localparam int DW = 32;
   localparam int MB = 304;
   localparam int TO = 16;
   localparam int BW = $clog2(MB + 1);

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   bsg_manycore_drlp_bcast_barrier_if #(
      .num_slaves_p(NS), .data_width_p(DW), .beats_width_p(BW)
   ) bus ();

   bsg_manycore_drlp_bcast_barrier #(
      .num_slaves_p(NS), .data_width_p(DW),
      .max_beats_p(MB), .timeout_cycles_p(TO)
   ) dut (
      .clk_i(clk_i),
      .reset_n_i(reset_n_i),
      .bus(bus)
   );

   task automatic idle_in();
      bus.job_v_i       = 1'b0;
      bus.job_mask_i    = '0;
      bus.job_beats_i   = '0;
      bus.data_v_i      = 1'b0;
      bus.data_i        = '0;
      bus.slave_ready_i = '0;
      bus.slave_done_i  = '0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input logic [3:0] m, input int b);
      idle_in();
      bus.job_v_i     = 1'b1;
      bus.job_mask_i  = m;
      bus.job_beats_i = BW'(b);
      #1;
      checks++;
      if (bus.job_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL job_ready got %b exp 1", bus.job_ready_o);
      end
      tick();
      bus.job_v_i = 1'b0;
   endtask

   task automatic test_reset();
      idle_in();
      reset_n_i = 1'b0;
      #3;
      checks++;
      if ({bus.job_ready_o, bus.busy_o, bus.bcast_v_o, bus.done_v_o,
           bus.data_yumi_o, bus.bcast_mask_o} !== {1'b1, 8'b0}) begin
         errors++;
         $display("FAIL reset_outs got %b%b%b%b%b%b exp 100000000",
            bus.job_ready_o, bus.busy_o, bus.bcast_v_o, bus.done_v_o,
            bus.data_yumi_o, bus.bcast_mask_o);
      end
      @(negedge clk_i);
      reset_n_i = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      start_job(4'b1111, 3);
      bus.slave_ready_i = '1;
      for (int i = 0; i < 4; i++) begin
         bus.data_v_i = (i < 3);
         bus.data_i   = 32'(10 + i);
         #1;
         checks++;
         if (bus.data_yumi_o !== (i < 3)) begin
            errors++;
            $display("FAIL b2b_yumi%0d got %b exp %b", i, bus.data_yumi_o, i < 3);
         end
         checks++;
         if (bus.bcast_v_o !== (i > 0)) begin
            errors++;
            $display("FAIL b2b_v%0d got %b exp %b", i, bus.bcast_v_o, i > 0);
         end
         if (i > 0) begin
            checks++;
            if (bus.bcast_data_o !== 32'(9 + i) || bus.bcast_last_o !== (i == 3)) begin
               errors++;
               $display("FAIL b2b_beat%0d got %h/%b exp %h/%b", i,
                  bus.bcast_data_o, bus.bcast_last_o, 32'(9 + i), i == 3);
            end
         end
         tick();
      end
      bus.data_v_i     = 1'b0;
      bus.slave_done_i = 4'b1111;
      #1;
      checks++;
      if (bus.bcast_v_o !== 1'b0 || bus.done_v_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_wait got v%b d%b b%b exp v0 d0 b1",
            bus.bcast_v_o, bus.done_v_o, bus.busy_o);
      end
      tick();
      bus.slave_done_i = '0;
      #1;
      checks++;
      if ({bus.done_v_o, bus.done_err_o, bus.done_missing_o} !== 6'b100000) begin
         errors++;
         $display("FAIL b2b_done got %b%b%b exp 100000",
            bus.done_v_o, bus.done_err_o, bus.done_missing_o);
      end
      tick();
      #1;
      checks++;
      if (bus.job_ready_o !== 1'b1 || bus.done_v_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle got r%b d%b exp r1 d0", bus.job_ready_o, bus.done_v_o);
      end
   endtask

   task automatic test_hold();
      start_job(4'b0101, 2);
      bus.data_v_i      = 1'b1;
      bus.data_i        = 32'h55;
      bus.slave_ready_i = 4'b1010;
      #1;
      checks++;
      if (bus.data_yumi_o !== 1'b1) begin
         errors++;
         $display("FAIL hold_first_yumi got %b exp 1", bus.data_yumi_o);
      end
      tick();
      bus.data_i = 32'h66;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (bus.bcast_v_o !== 1'b1 || bus.bcast_data_o !== 32'h55 ||
             bus.data_yumi_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_stall%0d got v%b %h y%b exp v1 55 y0",
               k, bus.bcast_v_o, bus.bcast_data_o, bus.data_yumi_o);
         end
         tick();
      end
      bus.slave_ready_i = 4'b0101;
      #1;
      checks++;
      if (bus.data_yumi_o !== 1'b1 || bus.bcast_data_o !== 32'h55) begin
         errors++;
         $display("FAIL hold_release got y%b %h exp y1 55",
            bus.data_yumi_o, bus.bcast_data_o);
      end
      tick();
      bus.data_v_i = 1'b0;
      #1;
      checks++;
      if (bus.bcast_v_o !== 1'b1 || bus.bcast_data_o !== 32'h66 || bus.bcast_last_o !== 1'b1) begin
         errors++;
         $display("FAIL hold_last got v%b %h l%b exp v1 66 l1",
            bus.bcast_v_o, bus.bcast_data_o, bus.bcast_last_o);
      end
      tick();
      bus.slave_done_i = 4'b0101;
      #1;
      checks++;
      if (bus.bcast_v_o !== 1'b0 || bus.bcast_mask_o !== 4'b0101) begin
         errors++;
         $display("FAIL hold_wait got v%b m%b exp v0 m0101", bus.bcast_v_o, bus.bcast_mask_o);
      end
      tick();
      bus.slave_done_i = '0;
      #1;
      checks++;
      if ({bus.done_v_o, bus.done_err_o, bus.done_missing_o} !== 6'b100000) begin
         errors++;
         $display("FAIL hold_done got %b%b%b exp 100000",
            bus.done_v_o, bus.done_err_o, bus.done_missing_o);
      end
      tick();
   endtask

   task automatic test_zero_beats();
      start_job(4'b0011, 0);
      for (int c = 1; c <= 8; c++) begin
         bus.data_v_i     = 1'b1;
         bus.slave_done_i = (c == 2) ? 4'b0001 : (c == 7) ? 4'b0010 : 4'b0000;
         #1;
         checks++;
         if (bus.data_yumi_o !== 1'b0 || bus.bcast_v_o !== 1'b0 || bus.done_v_o !== (c == 8)) begin
            errors++;
            $display("FAIL zero_c%0d got y%b v%b d%b exp y0 v0 d%b",
               c, bus.data_yumi_o, bus.bcast_v_o, bus.done_v_o, c == 8);
         end
         tick();
      end
      idle_in();
   endtask

   task automatic test_timeout();
      start_job(4'b1111, 0);
      for (int c = 1; c <= 17; c++) begin
         bus.slave_done_i = (c == 2) ? 4'b0111 : 4'b0000;
         #1;
         checks++;
         if (bus.done_v_o !== (c == 17)) begin
            errors++;
            $display("FAIL tmo_c%0d done got %b exp %b", c, bus.done_v_o, c == 17);
         end
         if (c == 17) begin
            checks++;
            if (bus.done_err_o !== 1'b1 || bus.done_missing_o !== 4'b1000) begin
               errors++;
               $display("FAIL tmo_report got e%b m%b exp e1 m1000",
                  bus.done_err_o, bus.done_missing_o);
            end
         end
         tick();
      end
      idle_in();
   endtask

   task automatic test_early_done();
      start_job(4'b1111, 4);
      bus.slave_ready_i = '1;
      for (int i = 0; i < 5; i++) begin
         bus.data_v_i     = (i < 4);
         bus.data_i       = 32'(100 + i);
         bus.slave_done_i = (i == 1) ? 4'b0100 : 4'b0000;
         tick();
      end
      bus.data_v_i     = 1'b0;
      bus.slave_done_i = 4'b1011;
      #1;
      checks++;
      if (bus.done_v_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL early_wait got d%b b%b exp d0 b1", bus.done_v_o, bus.busy_o);
      end
      tick();
      bus.slave_done_i = '0;
      #1;
      checks++;
      if ({bus.done_v_o, bus.done_err_o, bus.done_missing_o} !== 6'b100000) begin
         errors++;
         $display("FAIL early_done got %b%b%b exp 100000",
            bus.done_v_o, bus.done_err_o, bus.done_missing_o);
      end
      tick();
   endtask

   task automatic test_mask_zero();
      start_job(4'b0000, 0);
      #1;
      checks++;
      if (bus.done_v_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         errors++;
         $display("FAIL mask0_wait got d%b b%b exp d0 b1", bus.done_v_o, bus.busy_o);
      end
      tick();
      #1;
      checks++;
      if ({bus.done_v_o, bus.done_err_o, bus.done_missing_o} !== 6'b100000) begin
         errors++;
         $display("FAIL mask0_done got %b%b%b exp 100000",
            bus.done_v_o, bus.done_err_o, bus.done_missing_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      start_job(4'b0001, 3);
      bus.data_v_i = 1'b1;
      bus.data_i   = 32'h77;
      tick();
      #1;
      checks++;
      if (bus.bcast_v_o !== 1'b1) begin
         errors++;
         $display("FAIL rmid_held got %b exp 1", bus.bcast_v_o);
      end
      reset_n_i = 1'b0;
      #1;
      checks++;
      if ({bus.job_ready_o, bus.busy_o, bus.bcast_v_o, bus.bcast_last_o,
           bus.data_yumi_o, bus.done_v_o, bus.bcast_mask_o} !== {1'b1, 9'b0}) begin
         errors++;
         $display("FAIL rmid_outs got %b%b%b%b%b%b%b exp 1000000000",
            bus.job_ready_o, bus.busy_o, bus.bcast_v_o, bus.bcast_last_o,
            bus.data_yumi_o, bus.done_v_o, bus.bcast_mask_o);
      end
      idle_in();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (bus.done_v_o !== 1'b0 || bus.job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rmid_quiet%0d got d%b r%b exp d0 r1", c, bus.done_v_o, bus.job_ready_o);
         end
      end
      start_job(4'b0001, 1);
      bus.slave_ready_i = 4'b0001;
      bus.data_v_i      = 1'b1;
      bus.data_i        = 32'h88;
      tick();
      bus.data_v_i = 1'b0;
      #1;
      checks++;
      if (bus.bcast_v_o !== 1'b1 || bus.bcast_data_o !== 32'h88 || bus.bcast_last_o !== 1'b1) begin
         errors++;
         $display("FAIL rmid_new_beat got v%b %h l%b exp v1 88 l1",
            bus.bcast_v_o, bus.bcast_data_o, bus.bcast_last_o);
      end
      tick();
      bus.slave_done_i = 4'b0001;
      tick();
      bus.slave_done_i = '0;
      #1;
      checks++;
      if ({bus.done_v_o, bus.done_err_o, bus.done_missing_o} !== 6'b100000) begin
         errors++;
         $display("FAIL rmid_new_done got %b%b%b exp 100000",
            bus.done_v_o, bus.done_err_o, bus.done_missing_o);
      end
      tick();
   endtask

   task automatic test_random(input int jobs);
      for (int j = 0; j < jobs; j++) begin
         logic [3:0]  mask, got_miss, exp_miss;
         logic [31:0] words[8];
         logic [31:0] pdata;
         logic        got_err, exp_err, pv, pfire, fire;
         int          beats, widx, fidx, lastfire, done_c;
         int          t_wait, t_c, lastdone, exp_c;
         int          dcyc[4];
         mask  = 4'($urandom_range(1, 15));
         beats = $urandom_range(0, 5);
         for (int k = 0; k < 8; k++) words[k] = $urandom;
         for (int s = 0; s < 4; s++) dcyc[s] = $urandom_range(1, 30);
         start_job(mask, beats);
         widx = 0; fidx = 0; lastfire = 0; done_c = -1;
         pv = 1'b0; pfire = 1'b0; pdata = '0;
         got_err = 1'b0; got_miss = '0;
         for (int c = 1; c < 200 && done_c < 0; c++) begin
            bus.data_v_i = ($urandom_range(0, 3) != 0);
            bus.data_i   = (widx < beats) ? words[widx] : $urandom;
            for (int s = 0; s < 4; s++) begin
               bus.slave_ready_i[s] = ($urandom_range(0, 9) < 7);
               bus.slave_done_i[s]  = (dcyc[s] == c);
            end
            #1;
            fire = bus.bcast_v_o && ((bus.slave_ready_i | ~mask) == 4'hF);
            if (pv && !pfire) begin
               checks++;
               if (bus.bcast_v_o !== 1'b1 || bus.bcast_data_o !== pdata) begin
                  errors++;
                  $display("FAIL rnd%0d_hold c%0d got v%b %h exp v1 %h",
                     j, c, bus.bcast_v_o, bus.bcast_data_o, pdata);
               end
            end
            if (fire) begin
               checks++;
               if (fidx >= beats || bus.bcast_data_o !== words[fidx] ||
                   bus.bcast_last_o !== (fidx == beats - 1)) begin
                  errors++;
                  $display("FAIL rnd%0d_beat%0d got %h/%b exp %h/%b of %0d",
                     j, fidx, bus.bcast_data_o, bus.bcast_last_o,
                     words[fidx & 7], fidx == beats - 1, beats);
               end
               fidx++;
               if (fidx == beats) lastfire = c;
            end
            if (bus.data_yumi_o) begin
               checks++;
               if (bus.data_v_i !== 1'b1 || widx >= beats) begin
                  errors++;
                  $display("FAIL rnd%0d_yumi c%0d got idx %0d exp < %0d", j, c, widx, beats);
               end
               widx++;
            end
            checks++;
            if (bus.bcast_mask_o !== mask) begin
               errors++;
               $display("FAIL rnd%0d_mask got %b exp %b", j, bus.bcast_mask_o, mask);
            end
            if (bus.done_v_o === 1'b1) begin
               done_c   = c;
               got_err  = bus.done_err_o;
               got_miss = bus.done_missing_o;
            end
            pv = bus.bcast_v_o; pfire = fire; pdata = bus.bcast_data_o;
            tick();
         end
         idle_in();
         t_wait = (beats == 0) ? 1 : lastfire + 1;
         lastdone = 0;
         for (int s = 0; s < 4; s++)
            if (mask[s] && dcyc[s] > lastdone) lastdone = dcyc[s];
         t_c = (lastdone > t_wait) ? lastdone : t_wait;
         exp_miss = '0;
         if (t_c <= t_wait + TO - 1) begin
            exp_c = t_c + 1; exp_err = 1'b0;
         end else begin
            exp_c = t_wait + TO; exp_err = 1'b1;
            for (int s = 0; s < 4; s++)
               exp_miss[s] = mask[s] && (dcyc[s] > t_wait + TO - 1);
         end
         checks++;
         if (fidx != beats || done_c != exp_c) begin
            errors++;
            $display("FAIL rnd%0d_timing got beats %0d done@%0d exp beats %0d done@%0d",
               j, fidx, done_c, beats, exp_c);
         end
         checks++;
         if (got_err !== exp_err || got_miss !== exp_miss) begin
            errors++;
            $display("FAIL rnd%0d_report got e%b m%b exp e%b m%b",
               j, got_err, got_miss, exp_err, exp_miss);
         end
         #1;
         checks++;
         if (bus.job_ready_o !== 1'b1 || bus.bcast_mask_o !== 4'b0) begin
            errors++;
            $display("FAIL rnd%0d_idle got r%b m%b exp r1 m0", j, bus.job_ready_o, bus.bcast_mask_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold();
      test_zero_beats();
      test_timeout();
      test_early_done();
      test_mask_zero();
      test_reset_mid();
      test_random(25);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
